// File: rtl/f9pcap_dram_pkg.sv
// Shared definitions for the DRAM app-interface BRAM emulator: command encodings,
// error flag positions, engine state type and the stall LFSR step.
package f9pcap_dram_pkg;

  localparam logic [2:0] DRAM_CMD_WRITE = 3'b000;
  localparam logic [2:0] DRAM_CMD_READ  = 3'b001;

  localparam int ERR_ILLEGAL_CMD = 0;
  localparam int ERR_WREN_NO_END = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC_RD = 2'd1,
    ST_WAIT_WD = 2'd2
  } emu_state_t;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/dram_emu_fifo.sv
// Show-ahead FIFO used for both the command queue and the write-data queue.
// DEPTH must be a power of two, at least 2.
module dram_emu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = store_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    // a push into a full queue is legal only alongside a real pop
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dram_app_bram_emu.sv
// MIG-style app interface emulated on a byte-masked block RAM with fixed read latency.
// Optional macro DRAM_EMU_RANDOM_STALL_EN adds LFSR-driven stalls on app_rdy/app_wdf_rdy.
//   state      | meaning
//   ST_IDLE    | pop next command; writes with data ready complete here
//   ST_EXEC_RD | read the latched index into the read pipeline
//   ST_WAIT_WD | write popped, waiting for its data beat
module dram_app_bram_emu
  import f9pcap_dram_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 512,
  parameter int MEM_AW         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 1000,
  parameter int QDEPTH         = 4
) (
  input  logic                        dram_clk,
  input  logic                        dram_rst_n,
  output logic                        init_calib_complete,
  input  logic                        app_en,
  input  logic [2:0]                  app_cmd,
  input  logic [APP_ADDR_WIDTH-1:0]   app_addr,
  output logic                        app_rdy,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic [1:0]                  err_sticky
);

  localparam int MW    = APP_DATA_WIDTH / 8;
  localparam int CMD_W = 3 + MEM_AW;
  localparam int WD_W  = APP_DATA_WIDTH + MW;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam logic [CW-1:0] CAL_LAST = CW'(CALIB_CYCLES - 1);

  logic [CW-1:0]         cal_cnt_q, cal_cnt_d;
  logic                  cal_done_q, cal_done_d;
  logic                  cmd_en, wd_en;
  logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic                  wd_push, wd_pop, wd_full, wd_empty;
  logic [CMD_W-1:0]      cmd_dout;
  logic [WD_W-1:0]       wd_dout;
  logic [2:0]            head_cmd;
  logic [MEM_AW-1:0]     head_idx;
  logic [MW-1:0]         wd_mask;
  logic [APP_DATA_WIDTH-1:0] wd_data;
  emu_state_t            state_q, state_d;
  logic [MEM_AW-1:0]     cur_idx_q, cur_idx_d;
  logic                  mem_we, rd_issue, ill_cmd;
  logic [MEM_AW-1:0]     mem_widx;
  logic [1:0]            err_q, err_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [APP_DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];
  logic [APP_DATA_WIDTH-1:0] rd_dat_d [RD_LATENCY];
  logic [APP_DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic                  unused_addr;

  assign unused_addr = ^{app_addr[2:0], app_addr[APP_ADDR_WIDTH-1:MEM_AW+3]};

`ifdef DRAM_EMU_RANDOM_STALL_EN
  logic [15:0] lfsr_c_q, lfsr_w_q;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      lfsr_c_q <= 16'hACE1;
      lfsr_w_q <= 16'h1D0F;
    end else begin
      lfsr_c_q <= lfsr_next(lfsr_c_q);
      lfsr_w_q <= lfsr_next(lfsr_w_q);
    end
  end

  assign cmd_en = |lfsr_c_q[1:0];
  assign wd_en  = |lfsr_w_q[1:0];
`else
  assign cmd_en = 1'b1;
  assign wd_en  = 1'b1;
`endif

  assign init_calib_complete = cal_done_q;
  assign app_rdy     = cal_done_q && !cmd_full && cmd_en;
  assign app_wdf_rdy = cal_done_q && !wd_full && wd_en;
  assign cmd_push    = app_en && app_rdy;
  assign wd_push     = app_wdf_wren && app_wdf_rdy;
  assign {head_cmd, head_idx} = cmd_dout;
  assign {wd_mask, wd_data}   = wd_dout;

  dram_emu_fifo #(.WIDTH(CMD_W), .DEPTH(QDEPTH)) u_cmd_q (
    .clk(dram_clk), .rst_n(dram_rst_n),
    .push(cmd_push), .din({app_cmd, app_addr[3 +: MEM_AW]}),
    .pop(cmd_pop), .dout(cmd_dout), .full(cmd_full), .empty(cmd_empty)
  );

  dram_emu_fifo #(.WIDTH(WD_W), .DEPTH(QDEPTH)) u_wd_q (
    .clk(dram_clk), .rst_n(dram_rst_n),
    .push(wd_push), .din({app_wdf_mask, app_wdf_data}),
    .pop(wd_pop), .dout(wd_dout), .full(wd_full), .empty(wd_empty)
  );

  always_comb begin
    cal_cnt_d  = cal_cnt_q;
    cal_done_d = cal_done_q;
    if (!cal_done_q) begin
      if (cal_cnt_q == CAL_LAST) cal_done_d = 1'b1;
      else                       cal_cnt_d  = cal_cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    cmd_pop   = 1'b0;
    wd_pop    = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = head_idx;
    rd_issue  = 1'b0;
    ill_cmd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop   = 1'b1;
          cur_idx_d = head_idx;
          if (head_cmd == DRAM_CMD_READ) begin
            state_d = ST_EXEC_RD;
          end else if (head_cmd == DRAM_CMD_WRITE) begin
            if (!wd_empty) begin
              mem_we = 1'b1;
              wd_pop = 1'b1;
            end else begin
              state_d = ST_WAIT_WD;
            end
          end else begin
            ill_cmd = 1'b1;
          end
        end
      end
      ST_EXEC_RD: begin
        rd_issue = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_WAIT_WD: begin
        mem_widx = cur_idx_q;
        if (!wd_empty) begin
          mem_we  = 1'b1;
          wd_pop  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (ill_cmd) err_d[ERR_ILLEGAL_CMD] = 1'b1;
    if (wd_push && !app_wdf_end) err_d[ERR_WREN_NO_END] = 1'b1;
    rd_vld_d[0] = rd_issue;
    rd_dat_d[0] = rd_issue ? mem[cur_idx_q] : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_dat_d[i] = rd_dat_q[i-1];
    end
  end

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      cal_cnt_q  <= '0;
      cal_done_q <= 1'b0;
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      err_q      <= '0;
      rd_vld_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= '0;
    end else begin
      cal_cnt_q  <= cal_cnt_d;
      cal_done_q <= cal_done_d;
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_d[i];
    end
  end

  // contents deliberately survive reset
  always_ff @(posedge dram_clk) begin
    if (mem_we) begin
      for (int b = 0; b < MW; b++) begin
        if (!wd_mask[b]) mem[mem_widx][b*8 +: 8] <= wd_data[b*8 +: 8];
      end
    end
  end

  assign app_rd_data       = rd_dat_q[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
  assign err_sticky        = err_q;

endmodule

// File: tb/tb_dram_app_bram_emu.sv
// Directed bench for dram_app_bram_emu: calibration, masked writes, ordering, wrap, errors, reset.
module tb_dram_app_bram_emu;
  import f9pcap_dram_pkg::*;

  localparam int AW  = 28;
  localparam int DW  = 512;
  localparam int MW  = DW / 8;
  localparam int MAW = 10;
  localparam int RDL = 4;
  localparam int CAL = 20;
  localparam int QD  = 4;

  logic          dram_clk = 1'b0;
  logic          dram_rst_n = 1'b0;
  logic          init_calib_complete;
  logic          app_en = 1'b0;
  logic [2:0]    app_cmd = 3'b000;
  logic [AW-1:0] app_addr = '0;
  logic          app_rdy;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic [1:0]    err_sticky;

  int n_chk = 0;
  int n_fail = 0;

  dram_app_bram_emu #(
    .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .MEM_AW(MAW),
    .RD_LATENCY(RDL), .CALIB_CYCLES(CAL), .QDEPTH(QD)
  ) dut (
    .dram_clk(dram_clk), .dram_rst_n(dram_rst_n),
    .init_calib_complete(init_calib_complete),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .err_sticky(err_sticky)
  );

  always #5 dram_clk = ~dram_clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_calib"}, DW'(init_calib_complete), '0);
    chk({tag, "_rdy"}, DW'({app_rdy, app_wdf_rdy}), '0);
    chk({tag, "_rdvalid"}, DW'({app_rd_data_valid, app_rd_data_end}), '0);
    chk({tag, "_rddata"}, app_rd_data, '0);
    chk({tag, "_err"}, DW'(err_sticky), '0);
  endtask

  // releases reset at a negedge and checks ready rises on exactly the CAL-th edge
  task automatic release_and_calib(input string tag);
    logic early;
    int   vld;
    early = 1'b0;
    vld   = 0;
    dram_rst_n = 1'b1;
    for (int k = 1; k < CAL; k++) begin
      @(negedge dram_clk);
      early = early | init_calib_complete | app_rdy | app_wdf_rdy;
      if (app_rd_data_valid) vld++;
    end
    chk({tag, "_early_ready"}, DW'(early), '0);
    @(negedge dram_clk);
    chk({tag, "_ready_at_cal"}, DW'({init_calib_complete, app_rdy, app_wdf_rdy}), DW'(3'b111));
    chk({tag, "_no_valid"}, DW'(vld), '0);
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    int n;
    n = 0;
    app_en = 1'b1;
    app_cmd = c;
    app_addr = a;
    while (!app_rdy && n < 200) begin
      @(negedge dram_clk);
      n++;
    end
    chk("cmd_accept_timeout", DW'(n >= 200), '0);
    @(negedge dram_clk);
    app_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
    int n;
    n = 0;
    app_wdf_wren = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_end = e;
    while (!app_wdf_rdy && n < 200) begin
      @(negedge dram_clk);
      n++;
    end
    chk("wd_accept_timeout", DW'(n >= 200), '0);
    @(negedge dram_clk);
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  // one pop cycle plus one execute cycle precede the RDL pipeline stages
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int k;
    send_cmd(DRAM_CMD_READ, a);
    k = 0;
    while (!app_rd_data_valid && k < 50) begin
      @(negedge dram_clk);
      k++;
    end
    chk({tag, "_latency"}, DW'(k), DW'(RDL + 1));
    chk({tag, "_data"}, app_rd_data, exp);
    chk({tag, "_end"}, DW'(app_rd_data_end), DW'(1));
    @(negedge dram_clk);
    chk({tag, "_one_beat"}, DW'({app_rd_data_valid, app_rd_data_end}), '0);
  endtask

  initial begin
    logic [DW-1:0] pat_a5, pat_3, pat_w, pat_ne;
    int acc, vld;
    pat_a5 = {64{8'hA5}};
    pat_3  = {16{32'h1234_5678}};
    pat_w  = {16{32'hDEAD_BEEF}};
    pat_ne = {8{64'h0F1E_2D3C_4B5A_6978}};

    repeat (3) @(negedge dram_clk);
    chk_reset_outs("por");
    release_and_calib("calib0");

    send_data(pat_a5, '0, 1'b1);
    send_cmd(DRAM_CMD_WRITE, 28'h08);
    do_read("rd_a5", 28'h08, pat_a5);

    send_cmd(DRAM_CMD_WRITE, 28'h50);
    repeat (3) @(negedge dram_clk);
    chk("wait_wd_state", DW'(dut.state_q), DW'(ST_WAIT_WD));
    send_data(pat_3, '0, 1'b1);
    do_read("rd_late_data", 28'h50, pat_3);

    send_cmd(DRAM_CMD_WRITE, 28'h40);
    send_data({DW{1'b1}}, '0, 1'b1);
    send_cmd(DRAM_CMD_WRITE, 28'h40);
    send_data(DW'(8'h11), 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    do_read("rd_mask", 28'h40, {{(DW-8){1'b1}}, 8'h11});

    send_cmd(DRAM_CMD_WRITE, AW'(8 << MAW));
    send_data(pat_w, '0, 1'b1);
    do_read("rd_wrap", 28'h0, pat_w);

    send_cmd(3'b010, 28'h18);
    vld = 0;
    for (int i = 0; i < 12; i++) begin
      if (app_rd_data_valid) vld++;
      @(negedge dram_clk);
    end
    chk("illegal_no_data", DW'(vld), '0);
    chk("illegal_err", DW'(err_sticky), DW'(2'b01));

    send_data(pat_ne, '0, 1'b0);
    chk("no_end_err", DW'(err_sticky), DW'(2'b11));
    send_cmd(DRAM_CMD_WRITE, 28'h30);
    do_read("rd_no_end", 28'h30, pat_ne);

    // park the engine on a write with no data, then try five reads
    send_cmd(DRAM_CMD_WRITE, 28'h20);
    app_en = 1'b1;
    app_cmd = DRAM_CMD_READ;
    app_addr = 28'h08;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (app_rdy) acc++;
      @(negedge dram_clk);
    end
    app_en = 1'b0;
    chk("burst_accepts", DW'(acc), DW'(QD));
    chk("burst_rdy_low", DW'(app_rdy), '0);
    chk("burst_wait_state", DW'(dut.state_q), DW'(ST_WAIT_WD));
    dram_rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_burst");
    repeat (2) @(negedge dram_clk);
    release_and_calib("calib1");
    vld = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge dram_clk);
      if (app_rd_data_valid) vld++;
    end
    chk("burst_discarded", DW'(vld), '0);

    send_cmd(DRAM_CMD_READ, 28'h08);
    repeat (2) @(negedge dram_clk);
    dram_rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_inflight");
    repeat (2) @(negedge dram_clk);
    release_and_calib("calib2");
    vld = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge dram_clk);
      if (app_rd_data_valid) vld++;
    end
    chk("inflight_discarded", DW'(vld), '0);

    do_read("rd_retained", 28'h08, pat_a5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
